// File: rtl/response_statistics_multi_channel.sv
// Multi-channel PSL response statistics: per-code/class counters fed by a
// two-stage pipeline, with live and snapshot banks of sixteen counters.
module response_statistics_multi_channel #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  enabled_in,
  input  logic [NUM_CH-1:0]     resp_valid,
  input  logic [8*NUM_CH-1:0]   resp_code,
  input  logic [2*NUM_CH-1:0]   resp_cmd_class,
  input  logic                  clear_req,
  input  logic                  snap_req,
  output logic [16*CNT_W-1:0]   stats_live,
  output logic [16*CNT_W-1:0]   stats_snap,
  output logic                  snap_valid
);

  localparam int NCNT = 16;
  typedef logic [CNT_W-1:0] cnt_t;

  logic                en_q, en_d;
  logic [NUM_CH-1:0]   vld_p1_q, vld_p1_d;
  logic [8*NUM_CH-1:0] code_p1_q, code_p1_d;
  logic [2*NUM_CH-1:0] cls_p1_q, cls_p1_d;
  cnt_t                cnt_q [NCNT];
  cnt_t                cnt_d [NCNT];
  cnt_t                live_q [NCNT];
  cnt_t                live_d [NCNT];
  cnt_t                snap_q [NCNT];
  cnt_t                snap_d [NCNT];
  logic                snap_valid_q, snap_valid_d;
  logic [3:0]          inc [NCNT];

  function automatic logic [3:0] code_idx(input logic [7:0] code);
    case (code)
      8'h00:   return 4'd0;
      8'h06:   return 4'd5;
      8'h0A:   return 4'd6;
      8'h01:   return 4'd7;
      8'h03:   return 4'd8;
      8'h08:   return 4'd9;
      8'h07:   return 4'd10;
      8'h05:   return 4'd11;
      8'h04:   return 4'd12;
      default: return 4'd13;
    endcase
  endfunction

  // Sum is one bit wider than the counter so the carry flags an overflow.
  function automatic cnt_t acc(input cnt_t cur, input logic [3:0] step);
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + {{(CNT_W-3){1'b0}}, step};
    if (SATURATE != 0 && sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  // stage 1: register enable and gated responses
  always_comb begin
    en_d      = enabled_in;
    vld_p1_d  = resp_valid & {NUM_CH{en_q}};
    code_p1_d = resp_code;
    cls_p1_d  = resp_cmd_class;
  end

  // stage 2: per-counter increment from all valid channels
  always_comb begin
    for (int k = 0; k < NCNT; k++) inc[k] = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (vld_p1_q[c]) begin
        inc[code_idx(code_p1_q[8*c +: 8])] += 4'd1;
        if (code_p1_q[8*c +: 8] == 8'h00)
          inc[4'd1 + {2'b00, cls_p1_q[2*c +: 2]}] += 4'd1;
        inc[15] += 4'd1;
      end
    end
    inc[14] = 4'd1;
  end

  always_comb begin
    snap_valid_d = snap_req & en_q;
    for (int k = 0; k < NCNT; k++) begin
      live_d[k] = cnt_q[k];
      snap_d[k] = (snap_req & en_q) ? cnt_q[k] : snap_q[k];
      if (clear_req)  cnt_d[k] = '0;
      else if (en_q)  cnt_d[k] = acc(cnt_q[k], inc[k]);
      else            cnt_d[k] = cnt_q[k];
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      en_q         <= 1'b0;
      vld_p1_q     <= '0;
      code_p1_q    <= '0;
      cls_p1_q     <= '0;
      snap_valid_q <= 1'b0;
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k]  <= '0;
        live_q[k] <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      en_q         <= en_d;
      vld_p1_q     <= vld_p1_d;
      code_p1_q    <= code_p1_d;
      cls_p1_q     <= cls_p1_d;
      snap_valid_q <= snap_valid_d;
      for (int k = 0; k < NCNT; k++) begin
        cnt_q[k]  <= cnt_d[k];
        live_q[k] <= live_d[k];
        snap_q[k] <= snap_d[k];
      end
    end
  end

  for (genvar g = 0; g < NCNT; g++) begin : g_out
    assign stats_live[CNT_W*g +: CNT_W] = live_q[g];
    assign stats_snap[CNT_W*g +: CNT_W] = snap_q[g];
  end

  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_response_statistics_multi_channel.sv
// Bench: three instances (32-bit saturating, 8-bit saturating, 8-bit wrapping)
// driven in parallel and compared against a cycle-level reference model.
module tb_response_statistics_multi_channel;

  logic         clock = 1'b0;
  logic         rstn, enabled_in, clear_req, snap_req;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_code;
  logic [7:0]   resp_cmd_class;
  logic [511:0] live0, snap0;
  logic [127:0] live1, snap1, live2, snap2;
  logic         sv0, sv1, sv2;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clock = ~clock;

  response_statistics_multi_channel #(.NUM_CH(4), .CNT_W(32), .SATURATE(1)) dut0 (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .resp_valid(resp_valid),
    .resp_code(resp_code), .resp_cmd_class(resp_cmd_class), .clear_req(clear_req),
    .snap_req(snap_req), .stats_live(live0), .stats_snap(snap0), .snap_valid(sv0));
  response_statistics_multi_channel #(.NUM_CH(4), .CNT_W(8), .SATURATE(1)) dut1 (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .resp_valid(resp_valid),
    .resp_code(resp_code), .resp_cmd_class(resp_cmd_class), .clear_req(clear_req),
    .snap_req(snap_req), .stats_live(live1), .stats_snap(snap1), .snap_valid(sv1));
  response_statistics_multi_channel #(.NUM_CH(4), .CNT_W(8), .SATURATE(0)) dut2 (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .resp_valid(resp_valid),
    .resp_code(resp_code), .resp_cmd_class(resp_cmd_class), .clear_req(clear_req),
    .snap_req(snap_req), .stats_live(live2), .stats_snap(snap2), .snap_valid(sv2));

  // Reference model state: counts per instance, plus the one-cycle-delayed
  // view of enable and responses that the spec describes.
  bit              m_en;
  bit              m_vld [4];
  bit [7:0]        m_code [4];
  bit [1:0]        m_cls [4];
  longint unsigned m_cnt [3][16];
  longint unsigned m_live [3][16];
  longint unsigned m_snap [3][16];
  bit              m_sv;
  int              m_w [3]   = '{32, 8, 8};
  bit              m_sat [3] = '{1'b1, 1'b1, 1'b0};

  function automatic int counter_of(input bit [7:0] code);
    case (code)
      8'h00: return 0;   8'h06: return 5;   8'h0A: return 6;
      8'h01: return 7;   8'h03: return 8;   8'h08: return 9;
      8'h07: return 10;  8'h05: return 11;  8'h04: return 12;
      default: return 13;
    endcase
  endfunction

  function automatic longint unsigned madd(input longint unsigned cur, input int step,
                                           input int w, input bit sat);
    longint unsigned lim, s;
    lim = (64'd1 << w) - 1;
    s = cur + longint'(step);
    if (s > lim) s = sat ? lim : s - (lim + 1);
    return s;
  endfunction

  function automatic longint unsigned f0(input logic [511:0] v, input int k);
    return 64'(v[32*k +: 32]);
  endfunction

  function automatic longint unsigned f8(input logic [127:0] v, input int k);
    return 64'(v[8*k +: 8]);
  endfunction

  function automatic logic [511:0] pack(input int d, input bit s);
    logic [511:0]    v;
    longint unsigned x;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      x = s ? m_snap[d][k] : m_live[d][k];
      if (d == 0) v[32*k +: 32] = x[31:0];
      else        v[8*k +: 8]   = x[7:0];
    end
    return v;
  endfunction

  task automatic model_reset();
    m_en = 0; m_sv = 0;
    for (int c = 0; c < 4; c++) begin m_vld[c] = 0; m_code[c] = 0; m_cls[c] = 0; end
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 16; k++) begin m_cnt[d][k] = 0; m_live[d][k] = 0; m_snap[d][k] = 0; end
  endtask

  // Advance the model across the next rising edge using the current inputs.
  task automatic model_step();
    int inc [16];
    if (!rstn) begin model_reset(); return; end
    for (int k = 0; k < 16; k++) inc[k] = 0;
    for (int c = 0; c < 4; c++)
      if (m_vld[c]) begin
        inc[counter_of(m_code[c])]++;
        if (m_code[c] == 8'h00) inc[1 + int'(m_cls[c])]++;
        inc[15]++;
      end
    inc[14] = 1;
    m_sv = snap_req && m_en;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 16; k++) begin
        if (m_sv) m_snap[d][k] = m_cnt[d][k];
        m_live[d][k] = m_cnt[d][k];
        if (clear_req)  m_cnt[d][k] = 0;
        else if (m_en)  m_cnt[d][k] = madd(m_cnt[d][k], inc[k], m_w[d], m_sat[d]);
      end
    for (int c = 0; c < 4; c++) begin
      m_vld[c]  = resp_valid[c] && m_en;
      m_code[c] = resp_code[8*c +: 8];
      m_cls[c]  = resp_cmd_class[2*c +: 2];
    end
    m_en = enabled_in;
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    resp_valid = '0; resp_code = '0; resp_cmd_class = '0; clear_req = 0; snap_req = 0;
  endtask

  task automatic do_clear();
    idle_inputs(); clear_req = 1; tick(); clear_req = 0; tick(); tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (live0 !== '0) begin n_bad++; $display("FAIL reset_live0: got %h want 0", live0); end
    n_cmp++; if (snap0 !== '0) begin n_bad++; $display("FAIL reset_snap0: got %h want 0", snap0); end
    n_cmp++; if ({sv0, sv1, sv2} !== 3'b000) begin n_bad++; $display("FAIL reset_snap_valid: got %b want 000", {sv0, sv1, sv2}); end
    n_cmp++; if ({live1, live2, snap1, snap2} !== '0) begin n_bad++; $display("FAIL reset_8bit: nonzero output after reset"); end
    rstn = 1; enabled_in = 1; tick(); tick();
  endtask

  task automatic test_done_classes();
    do_clear();
    resp_valid = 4'hF; resp_code = '0; resp_cmd_class = {2'd3, 2'd2, 2'd1, 2'd0};
    tick(); idle_inputs(); tick(); tick();
    n_cmp++; if (f0(live0, 0) != 4) begin n_bad++; $display("FAIL done_count: got %0d want 4", f0(live0, 0)); end
    for (int k = 1; k <= 4; k++) begin
      n_cmp++; if (f0(live0, k) != 1) begin n_bad++; $display("FAIL done_class%0d: got %0d want 1", k - 1, f0(live0, k)); end
    end
    n_cmp++; if (f0(live0, 15) != 4) begin n_bad++; $display("FAIL done_total: got %0d want 4", f0(live0, 15)); end
    n_cmp++; if (live0 !== pack(0, 0)) begin n_bad++; $display("FAIL done_vector: got %h want %h", live0, pack(0, 0)); end
  endtask

  task automatic test_paged_unknown();
    do_clear();
    resp_valid = 4'b0011; resp_code = {16'h0000, 8'h02, 8'h0A};
    tick(); idle_inputs(); tick(); tick();
    n_cmp++; if (f0(live0, 6) != 1) begin n_bad++; $display("FAIL paged: got %0d want 1", f0(live0, 6)); end
    n_cmp++; if (f0(live0, 13) != 1) begin n_bad++; $display("FAIL unknown: got %0d want 1", f0(live0, 13)); end
    n_cmp++; if (f0(live0, 15) != 2) begin n_bad++; $display("FAIL pu_total: got %0d want 2", f0(live0, 15)); end
    n_cmp++; if (f0(live0, 0) != 0) begin n_bad++; $display("FAIL pu_done: got %0d want 0", f0(live0, 0)); end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 75; i++) begin
      resp_valid = 4'hF; resp_code = {4{8'h06}}; tick();
    end
    idle_inputs(); tick(); tick(); tick();
    n_cmp++; if (f0(live0, 5) != 300) begin n_bad++; $display("FAIL flushed_32: got %0d want 300", f0(live0, 5)); end
    n_cmp++; if (f8(live1, 5) != 255) begin n_bad++; $display("FAIL flushed_sat8: got %0d want 255", f8(live1, 5)); end
    n_cmp++; if (f8(live2, 5) != 44) begin n_bad++; $display("FAIL flushed_wrap8: got %0d want 44", f8(live2, 5)); end
    n_cmp++; if (f8(live1, 15) != 255) begin n_bad++; $display("FAIL total_sat8: got %0d want 255", f8(live1, 15)); end
    n_cmp++; if ({384'b0, live2} !== pack(2, 0)) begin n_bad++; $display("FAIL wrap8_vector: got %h want %h", live2, pack(2, 0)); end
  endtask

  task automatic test_snap_clear();
    do_clear();
    for (int i = 0; i < 7; i++) begin resp_valid = 4'b0001; resp_code = '0; tick(); end
    idle_inputs(); tick(); tick(); tick();
    n_cmp++; if (f0(live0, 0) != 7) begin n_bad++; $display("FAIL sc_pre_done: got %0d want 7", f0(live0, 0)); end
    snap_req = 1; clear_req = 1; tick(); idle_inputs();
    n_cmp++; if (sv0 !== 1'b1) begin n_bad++; $display("FAIL sc_pulse: got %b want 1", sv0); end
    n_cmp++; if (f0(snap0, 0) != 7) begin n_bad++; $display("FAIL sc_snap_done: got %0d want 7", f0(snap0, 0)); end
    tick();
    n_cmp++; if (sv0 !== 1'b0) begin n_bad++; $display("FAIL sc_pulse_end: got %b want 0", sv0); end
    n_cmp++; if (f0(live0, 0) != 0) begin n_bad++; $display("FAIL sc_live_cleared: got %0d want 0", f0(live0, 0)); end
    n_cmp++; if (f0(snap0, 0) != 7) begin n_bad++; $display("FAIL sc_snap_hold: got %0d want 7", f0(snap0, 0)); end
  endtask

  task automatic test_disable();
    logic [511:0] held;
    idle_inputs(); enabled_in = 0; tick(); tick(); tick();
    held = pack(0, 0);
    for (int i = 0; i < 10; i++) begin
      resp_valid = 4'hF; resp_code = $urandom; resp_cmd_class = 8'($urandom); snap_req = 1;
      tick();
      n_cmp++; if (live0 !== held) begin n_bad++; $display("FAIL dis_hold%0d: got %h want %h", i, live0, held); end
      n_cmp++; if (sv0 !== 1'b0) begin n_bad++; $display("FAIL dis_snap%0d: got %b want 0", i, sv0); end
    end
    idle_inputs(); clear_req = 1; tick(); clear_req = 0; tick();
    n_cmp++; if (live0 !== '0) begin n_bad++; $display("FAIL dis_clear: got %h want 0", live0); end
    enabled_in = 1; tick(); tick();
  endtask

  task automatic test_reset_midflight();
    do_clear();
    resp_valid = 4'hF; resp_code = '0; tick();
    resp_valid = 4'hF; resp_code = {4{8'h01}};
    rstn = 0; #1;
    n_cmp++; if (live0 !== '0 || snap0 !== '0 || sv0 !== 1'b0) begin n_bad++; $display("FAIL mid_reset_out: got %h want 0", live0); end
    tick(); tick(); idle_inputs();
    rstn = 1;
    tick(); tick(); tick(); tick();
    n_cmp++; if (f0(live0, 15) != 0) begin n_bad++; $display("FAIL mid_total: got %0d want 0", f0(live0, 15)); end
    n_cmp++; if (f0(live0, 7) != 0 || f0(live0, 0) != 0) begin n_bad++; $display("FAIL mid_codes: got %0d/%0d want 0/0", f0(live0, 0), f0(live0, 7)); end
    n_cmp++; if (live0 !== pack(0, 0)) begin n_bad++; $display("FAIL mid_vector: got %h want %h", live0, pack(0, 0)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enabled_in = ($urandom_range(0, 9) != 0);
      resp_valid = 4'($urandom);
      for (int c = 0; c < 4; c++)
        resp_code[8*c +: 8] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 11));
      resp_cmd_class = 8'($urandom);
      clear_req = ($urandom_range(0, 29) == 0);
      snap_req  = ($urandom_range(0, 7) == 0);
      tick();
      n_cmp++; if (live0 !== pack(0, 0)) begin n_bad++; $display("FAIL rnd_live0 @%0d: got %h want %h", i, live0, pack(0, 0)); end
      n_cmp++; if (snap0 !== pack(0, 1)) begin n_bad++; $display("FAIL rnd_snap0 @%0d: got %h want %h", i, snap0, pack(0, 1)); end
      n_cmp++; if ({384'b0, live1} !== pack(1, 0)) begin n_bad++; $display("FAIL rnd_live1 @%0d: got %h want %h", i, live1, pack(1, 0)); end
      n_cmp++; if ({384'b0, live2} !== pack(2, 0)) begin n_bad++; $display("FAIL rnd_live2 @%0d: got %h want %h", i, live2, pack(2, 0)); end
      n_cmp++; if ({384'b0, snap2} !== pack(2, 1)) begin n_bad++; $display("FAIL rnd_snap2 @%0d: got %h want %h", i, snap2, pack(2, 1)); end
      n_cmp++; if ({sv0, sv1, sv2} !== {3{m_sv}}) begin n_bad++; $display("FAIL rnd_sv @%0d: got %b want %b", i, {sv0, sv1, sv2}, {3{m_sv}}); end
    end
    idle_inputs(); enabled_in = 1;
  endtask

  initial begin
    rstn = 0; enabled_in = 0; idle_inputs(); model_reset();
    @(negedge clock);
    test_reset();
    test_done_classes();
    test_paged_unknown();
    test_saturation();
    test_snap_clear();
    test_disable();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
